// File: rtl/neuron_synapse_bank_p.sv
// Synapse weight bank for one neuron: programmable weight table, hash weights outside it,
// pipelined saturating LTP/LTD, and a decay sweep. Optional entry locking under SYN_LOCK_EN.
module neuron_synapse_bank_p #(
  parameter int ADDR_W      = 6,
  parameter int PROG_BITS   = 4,
  parameter int W_W         = 2,
  parameter int DECAY_FLOOR = 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              ena,
  input  logic [ADDR_W-1:0]                                 addr,
  input  logic                                              polarity,
  input  logic                                              cfg_set_widx_fire,
  input  logic                                              cfg_write_w_fire,
  input  logic [((PROG_BITS > W_W) ? PROG_BITS : W_W)-1:0]  cfg_arg,
  input  logic                                              ltp_req,
  input  logic [PROG_BITS-1:0]                              ltp_idx,
  input  logic                                              ltd_req,
  input  logic [PROG_BITS-1:0]                              ltd_idx,
  input  logic                                              decay_start,
`ifdef SYN_LOCK_EN
  input  logic                                              cfg_lock_fire,
`endif
  output logic [(W_W << PROG_BITS)-1:0]                     wtab,
  output logic [PROG_BITS-1:0]                              pending_widx,
  output logic                                              is_prog_addr,
  output logic [W_W-1:0]                                    w_eff,
  output logic                                              decay_busy,
  output logic                                              plast_drop
);

  localparam int PROG_N = 1 << PROG_BITS;
  localparam logic [W_W-1:0]       ONE   = W_W'(1);
  localparam logic [W_W-1:0]       W_MAX = '1;
  localparam logic [W_W-1:0]       FLOOR = W_W'(DECAY_FLOOR);
  localparam logic [PROG_BITS-1:0] LAST  = '1;

  typedef enum logic {S_IDLE, S_SWEEP} state_e;

  state_e               state_q, state_d;
  logic [W_W-1:0]       wtab_q [PROG_N];
  logic [W_W-1:0]       wtab_d [PROG_N];
  logic [PROG_BITS-1:0] pend_q, pend_d;
  logic [PROG_BITS-1:0] sidx_q, sidx_d;
  logic                 drop_q, drop_d;
  logic                 ltp_v_q, ltp_v_d, ltd_v_q, ltd_v_d;
  logic [PROG_BITS-1:0] ltp_idx_q, ltp_idx_d, ltd_idx_q, ltd_idx_d;
  logic [PROG_N-1:0]    lock_q, lock_d;
  logic [W_W-1:0]       hash;

  always_comb begin
    pend_d    = pend_q;
    state_d   = state_q;
    sidx_d    = sidx_q;
    drop_d    = 1'b0;
    lock_d    = lock_q;
    ltp_idx_d = ltp_idx;
    ltd_idx_d = ltd_idx;
    // Opposing requests to the same entry cancel before entering the pipeline.
    ltp_v_d = ltp_req && !(ltd_req && (ltp_idx == ltd_idx));
    ltd_v_d = ltd_req && !(ltp_req && (ltp_idx == ltd_idx));
    if (cfg_set_widx_fire) pend_d = cfg_arg[PROG_BITS-1:0];
`ifdef SYN_LOCK_EN
    if (cfg_lock_fire) lock_d[pend_q] = cfg_arg[0];
`endif

    case (state_q)
      S_IDLE: begin
        if (decay_start) begin
          state_d = S_SWEEP;
          sidx_d  = '0;
        end
      end
      S_SWEEP: begin
        sidx_d = sidx_q + PROG_BITS'(1);
        if (sidx_q == LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Per-entry writer arbitration: config write, then plasticity, then decay.
    for (int k = 0; k < PROG_N; k++) begin
      wtab_d[k] = wtab_q[k];
      if (cfg_write_w_fire && (pend_q == PROG_BITS'(k))) begin
        wtab_d[k] = cfg_arg[W_W-1:0];
        if ((ltp_v_q && ltp_idx_q == PROG_BITS'(k)) || (ltd_v_q && ltd_idx_q == PROG_BITS'(k)))
          drop_d = 1'b1;
      end else if ((ltp_v_q && ltp_idx_q == PROG_BITS'(k)) ||
                   (ltd_v_q && ltd_idx_q == PROG_BITS'(k))) begin
        if (lock_q[k]) begin
          drop_d = 1'b1;
        end else if (ltp_v_q && ltp_idx_q == PROG_BITS'(k)) begin
          if (wtab_q[k] != W_MAX) wtab_d[k] = wtab_q[k] + ONE;
        end else begin
          if (wtab_q[k] != '0) wtab_d[k] = wtab_q[k] - ONE;
        end
      end else if (state_q == S_SWEEP && sidx_q == PROG_BITS'(k) && !lock_q[k]) begin
        if (wtab_q[k] > FLOOR) wtab_d[k] = wtab_q[k] - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      sidx_q    <= '0;
      drop_q    <= 1'b0;
      ltp_v_q   <= 1'b0;
      ltd_v_q   <= 1'b0;
      ltp_idx_q <= '0;
      ltd_idx_q <= '0;
      lock_q    <= '0;
      for (int k = 0; k < PROG_N; k++) wtab_q[k] <= '0;
    end else if (ena) begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      sidx_q    <= sidx_d;
      drop_q    <= drop_d;
      ltp_v_q   <= ltp_v_d;
      ltd_v_q   <= ltd_v_d;
      ltp_idx_q <= ltp_idx_d;
      ltd_idx_q <= ltd_idx_d;
      lock_q    <= lock_d;
      for (int k = 0; k < PROG_N; k++) wtab_q[k] <= wtab_d[k];
    end
  end

  // Hash bit b folds every address bit whose polarity-rotated position lands on b.
  always_comb begin
    hash = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      hash[(i + int'(polarity)) % W_W] = hash[(i + int'(polarity)) % W_W] ^ addr[i];
    end
  end

  always_comb begin
    wtab = '0;
    for (int k = 0; k < PROG_N; k++) wtab[k*W_W +: W_W] = wtab_q[k];
  end

  assign is_prog_addr = (addr[ADDR_W-1:PROG_BITS] == '0);
  assign w_eff        = is_prog_addr ? wtab_q[addr[PROG_BITS-1:0]]
                                     : ((hash == '0) ? ONE : hash);
  assign pending_widx = pend_q;
  assign decay_busy   = (state_q == S_SWEEP);
  assign plast_drop   = drop_q;

endmodule

// File: tb/tb_neuron_synapse_bank_p.sv
// Directed bench for neuron_synapse_bank_p with a cycle-level reference model of the weight bank.
module tb_neuron_synapse_bank_p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [5:0]  addr = '0;
  logic        polarity = 1'b0;
  logic        cfg_set_widx_fire = 1'b0;
  logic        cfg_write_w_fire = 1'b0;
  logic [3:0]  cfg_arg = '0;
  logic        ltp_req = 1'b0;
  logic [3:0]  ltp_idx = '0;
  logic        ltd_req = 1'b0;
  logic [3:0]  ltd_idx = '0;
  logic        decay_start = 1'b0;
`ifdef SYN_LOCK_EN
  logic        cfg_lock_fire = 1'b0;
`endif
  logic [31:0] wtab;
  logic [3:0]  pending_widx;
  logic        is_prog_addr;
  logic [1:0]  w_eff;
  logic        decay_busy;
  logic        plast_drop;

  int n_vec  = 0;
  int n_miss = 0;

  neuron_synapse_bank_p dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .addr(addr), .polarity(polarity),
    .cfg_set_widx_fire(cfg_set_widx_fire), .cfg_write_w_fire(cfg_write_w_fire),
    .cfg_arg(cfg_arg), .ltp_req(ltp_req), .ltp_idx(ltp_idx), .ltd_req(ltd_req),
    .ltd_idx(ltd_idx), .decay_start(decay_start),
`ifdef SYN_LOCK_EN
    .cfg_lock_fire(cfg_lock_fire),
`endif
    .wtab(wtab), .pending_widx(pending_widx), .is_prog_addr(is_prog_addr),
    .w_eff(w_eff), .decay_busy(decay_busy), .plast_drop(plast_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit is_ltp; int idx; } preq_t;
  int    m_wt [16];
  int    m_pend = 0;
  bit    m_busy = 0;
  int    m_sidx = 0;
  bit    m_drop = 0;
  preq_t m_pipe [$];

  task automatic model_reset();
    foreach (m_wt[k]) m_wt[k] = 0;
    m_pend = 0; m_busy = 0; m_sidx = 0; m_drop = 0;
    m_pipe.delete();
  endtask

  task automatic model_step();
    int nw [16];
    bit touched [16];
    bit drop;
    preq_t r;
    drop = 0;
    foreach (nw[k]) begin nw[k] = m_wt[k]; touched[k] = 0; end
    if (cfg_write_w_fire) nw[m_pend] = int'(cfg_arg) % 4;
    foreach (m_pipe[j]) begin
      if (cfg_write_w_fire && m_pipe[j].idx == m_pend) drop = 1;
      else begin
        touched[m_pipe[j].idx] = 1;
        if (m_pipe[j].is_ltp) nw[m_pipe[j].idx] = (m_wt[m_pipe[j].idx] >= 3) ? 3 : m_wt[m_pipe[j].idx] + 1;
        else                  nw[m_pipe[j].idx] = (m_wt[m_pipe[j].idx] <= 0) ? 0 : m_wt[m_pipe[j].idx] - 1;
      end
    end
    if (m_busy) begin
      if (!(cfg_write_w_fire && m_sidx == m_pend) && !touched[m_sidx] && m_wt[m_sidx] > 1)
        nw[m_sidx] = m_wt[m_sidx] - 1;
      m_sidx++;
      if (m_sidx == 16) begin m_busy = 0; m_sidx = 0; end
    end else if (decay_start) begin
      m_busy = 1; m_sidx = 0;
    end
    m_pipe.delete();
    if (!(ltp_req && ltd_req && ltp_idx == ltd_idx)) begin
      if (ltp_req) begin r.is_ltp = 1; r.idx = int'(ltp_idx); m_pipe.push_back(r); end
      if (ltd_req) begin r.is_ltp = 0; r.idx = int'(ltd_idx); m_pipe.push_back(r); end
    end
    if (cfg_set_widx_fire) m_pend = int'(cfg_arg);
    foreach (m_wt[k]) m_wt[k] = nw[k];
    m_drop = drop;
  endtask

  function automatic logic [1:0] model_weff();
    int h;
    if (addr[5:4] == 2'b00) return m_wt[addr[3:0]][1:0];
    h = 0;
    for (int i = 0; i < 6; i++) if (addr[i]) h = h ^ (1 << ((i + int'(polarity)) % 2));
    if (h == 0) h = 1;
    return h[1:0];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else if (ena) model_step();
    #1;
    if (rst_n) begin
      logic [31:0] e;
      for (int k = 0; k < 16; k++) e[k*2 +: 2] = m_wt[k][1:0];
      chk("model_wtab", wtab, e);
      chk("model_pending", pending_widx, m_pend[3:0]);
      chk("model_busy", decay_busy, m_busy);
      chk("model_drop", plast_drop, m_drop);
      chk("model_weff", w_eff, model_weff());
      chk("model_isprog", is_prog_addr, addr[5:4] == 2'b00);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [1:0] wt(input int k);
    return wtab[k*2 +: 2];
  endfunction

  task automatic write_entry(input int idx, input int val);
    cfg_set_widx_fire = 1; cfg_arg = idx[3:0]; cyc(1);
    cfg_set_widx_fire = 0; cfg_write_w_fire = 1; cfg_arg = val[3:0]; cyc(1);
    cfg_write_w_fire = 0;
  endtask

  task automatic run_sweep(input int ena_off_at, input int restart_at, output int cnt);
    decay_start = 1; cyc(1); decay_start = 0;
    cnt = 0;
    while (decay_busy && cnt < 40) begin
      if (cnt == ena_off_at) ena = 0;
      if (cnt == ena_off_at + 3) ena = 1;
      decay_start = (cnt == restart_at);
      cyc(1);
      cnt++;
    end
    decay_start = 0; ena = 1;
  endtask

  initial begin
    int cnt;
    cyc(2);
    chk("rst_wtab", wtab, 0);
    chk("rst_pending", pending_widx, 0);
    chk("rst_busy", decay_busy, 0);
    chk("rst_drop", plast_drop, 0);
    rst_n = 1; cyc(1);

    // Config write and lookups.
    write_entry(3, 2);
    addr = 6'h03; #1;
    chk("weff_prog3", w_eff, 2);
    chk("isprog_03", is_prog_addr, 1);
    addr = 6'h3C; polarity = 0; #1;
    chk("weff_hash_zero_forced", w_eff, 1);
    chk("isprog_3c", is_prog_addr, 0);
    addr = 6'h30; #1;
    chk("weff_hash_30", w_eff, 3);
    addr = 6'h10; #1;
    chk("weff_hash_10_p0", w_eff, 1);
    polarity = 1; #1;
    chk("weff_hash_10_p1", w_eff, 2);
    cyc(1);

    // LTP saturation and back-to-back LTD.
    write_entry(5, 3);
    ltp_req = 1; ltp_idx = 5; cyc(1); ltp_req = 0; cyc(1);
    chk("ltp_sat", wt(5), 3);
    ltd_req = 1; ltd_idx = 5; cyc(2);
    chk("ltd_first", wt(5), 2);
    cyc(1);
    chk("ltd_second", wt(5), 1);
    ltd_req = 0; cyc(1);
    chk("ltd_third", wt(5), 0);
    ltd_req = 1; cyc(1); ltd_req = 0; cyc(2);
    chk("ltd_floor0", wt(5), 0);

    // Opposing requests cancel.
    write_entry(2, 1);
    ltp_req = 1; ltp_idx = 2; ltd_req = 1; ltd_idx = 2; cyc(1);
    ltp_req = 0; ltd_req = 0;
    chk("cancel_drop_a", plast_drop, 0);
    cyc(1);
    chk("cancel_drop_b", plast_drop, 0);
    chk("cancel_val", wt(2), 1);

    // Plasticity lost to a config write.
    write_entry(7, 2);
    ltp_req = 1; ltp_idx = 7; cyc(1); ltp_req = 0;
    cfg_write_w_fire = 1; cfg_arg = 0; cyc(1); cfg_write_w_fire = 0;
    chk("drop_val", wt(7), 0);
    chk("drop_pulse", plast_drop, 1);
    cyc(1);
    chk("drop_clear", plast_drop, 0);

    // Decay sweeps.
    for (int i = 0; i < 16; i++) write_entry(i, 3);
    run_sweep(-1, -1, cnt);
    chk("sweep1_len", cnt, 16);
    chk("sweep1_vals", wtab, 32'hAAAA_AAAA);
    run_sweep(-1, -1, cnt);
    chk("sweep2_len", cnt, 16);
    chk("sweep2_vals", wtab, 32'h5555_5555);
    run_sweep(-1, 5, cnt);
    chk("sweep3_len_restart_ignored", cnt, 16);
    chk("sweep3_vals", wtab, 32'h5555_5555);
    run_sweep(5, -1, cnt);
    chk("sweep_ena_stall_len", cnt, 19);

    // Reset in the middle of a sweep.
    decay_start = 1; cyc(1); decay_start = 0;
    cyc(8);
    rst_n = 0; #1;
    chk("midrst_wtab", wtab, 0);
    chk("midrst_busy", decay_busy, 0);
    cyc(1); rst_n = 1; cyc(1);
    cfg_write_w_fire = 1; cfg_arg = 3; cyc(1); cfg_write_w_fire = 0;
    decay_start = 1; cyc(1); decay_start = 0; cyc(1);
    chk("restart_idx0", wt(0), 2);
    cnt = 0;
    while (decay_busy && cnt < 40) begin cyc(1); cnt++; end
    chk("restart_len", cnt, 15);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
